// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings for the pong game-flow logic.
//   state_e  - match_sequencer state encoding (also driven on its debug port)
//   winner_e - winner codes
//   SCORE_W_DFLT - default score counter width
package pong_pkg;

    localparam int unsigned SCORE_W_DFLT = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WINNER_NONE = 2'b00,
        WINNER_P1   = 2'b01,
        WINNER_P2   = 2'b10
    } winner_e;

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer for an asynchronous button followed by a
// rising-edge detector.
//   clk     in  : destination clock
//   reset   in  : synchronous, active-high
//   btn_in  in  : raw asynchronous button level
//   pulse_c out : one-cycle pulse on each synchronized rising edge (decoded
//                 from flops, no input-to-output combinational path)
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_c
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q,  edge_d;

    // Shift the button through two sync stages plus one edge-history stage
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    assign pulse_c = sync2_q & ~edge_q;

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: game-flow controller for pong. Drives the game datapath's
// reset/play inputs through serve -> rally -> point -> game-over, keeps both
// scores and paces SERVE/POINT pauses in frame ticks.
// Build option: define AUTO_SERVE_EN to leave SERVE after SERVE_FRAMES ticks;
// otherwise SERVE waits for a start press and SERVE_FRAMES is unused.
//   px_clk     in  : pixel clock
//   reset      in  : synchronous, active-high
//   endframe   in  : end-of-frame level (px_clk domain)
//   start      in  : raw start button (asynchronous)
//   miss_ply1  in  : ball passed player 1 (point to player 2)
//   miss_ply2  in  : ball passed player 2 (point to player 1)
//   game_rst   out : datapath reset
//   play       out : motion enable
//   score_ply1 out : player 1 score
//   score_ply2 out : player 2 score
//   serve_to   out : next serve direction (0 = toward player 1)
//   winner     out : 00 none, 01 player 1, 10 player 2
//   state      out : current state (debug)
module match_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SCORE_W      = SCORE_W_DFLT,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               endframe,
    input  logic               start,
    input  logic               miss_ply1,
    input  logic               miss_ply2,
    output logic               game_rst,
    output logic               play,
    output logic [SCORE_W-1:0] score_ply1,
    output logic [SCORE_W-1:0] score_ply2,
    output logic               serve_to,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CNT_W      = ($clog2(MAX_FRAMES) < 1) ? 1 : $clog2(MAX_FRAMES);

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   POINT_END = CNT_W'(POINT_FRAMES - 1);
`ifdef AUTO_SERVE_EN
    localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_FRAMES - 1);
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] s1_q, s1_d;
    logic [SCORE_W-1:0] s2_q, s2_d;
    logic               sto_q, sto_d;
    winner_e            win_q, win_d;
    logic               game_rst_q, game_rst_d;
    logic               play_q, play_d;
    logic               endframe_q, endframe_d;

    logic               tick_c;
    logic               start_pulse_c;

    btn_sync_edge u_start_sync (
        .clk     (px_clk),
        .reset   (reset),
        .btn_in  (start),
        .pulse_c (start_pulse_c)
    );

    // Frame tick: rising edge of endframe against its one-cycle delay
    assign endframe_d = endframe;
    assign tick_c     = endframe & ~endframe_q;

    // Next-state, frame counter, score and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        sto_d   = sto_q;
        win_d   = win_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_pulse_c) begin
                    state_d = ST_SERVE;
                    s1_d    = '0;
                    s2_d    = '0;
                    sto_d   = 1'b0;
                    win_d   = WINNER_NONE;
                end
            end
            ST_SERVE: begin
`ifdef AUTO_SERVE_EN
                if (tick_c) begin
                    if (cnt_q == SERVE_END) state_d = ST_PLAY;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
`else
                if (start_pulse_c) state_d = ST_PLAY;
`endif
            end
            ST_PLAY: begin
                // Simultaneous misses: nobody scores, serve direction kept
                if (miss_ply1 && miss_ply2) begin
                    state_d = ST_POINT;
                end else if (miss_ply1) begin
                    if (s2_q < WIN_VAL) s2_d = s2_q + SCORE_W'(1);
                    sto_d   = 1'b0;
                    state_d = ST_POINT;
                end else if (miss_ply2) begin
                    if (s1_q < WIN_VAL) s1_d = s1_q + SCORE_W'(1);
                    sto_d   = 1'b1;
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (tick_c) begin
                    if (cnt_q == POINT_END) begin
                        if (s1_q == WIN_VAL) begin
                            state_d = ST_GAMEOVER;
                            win_d   = WINNER_P1;
                        end else if (s2_q == WIN_VAL) begin
                            state_d = ST_GAMEOVER;
                            win_d   = WINNER_P2;
                        end else begin
                            state_d = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAMEOVER: begin
                if (start_pulse_c) begin
                    state_d = ST_SERVE;
                    s1_d    = '0;
                    s2_d    = '0;
                    win_d   = WINNER_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state entry starts the pause count afresh, so a tick on the
        // entry edge is not counted
        if (state_d != state_q) cnt_d = '0;

        game_rst_d = (state_d == ST_IDLE) || (state_d == ST_SERVE);
        play_d     = (state_d == ST_PLAY);
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            sto_q      <= 1'b0;
            win_q      <= WINNER_NONE;
            game_rst_q <= 1'b1;
            play_q     <= 1'b0;
            endframe_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            sto_q      <= sto_d;
            win_q      <= win_d;
            game_rst_q <= game_rst_d;
            play_q     <= play_d;
            endframe_q <= endframe_d;
        end
    end

    assign game_rst   = game_rst_q;
    assign play       = play_q;
    assign score_ply1 = s1_q;
    assign score_ply2 = s2_q;
    assign serve_to   = sto_q;
    assign winner     = win_q;
    assign state      = state_q;

endmodule
